sv32_page_walker: RTL and testbench

//  Hardware Sv32 page-table walker; services ITLB/DTLB misses. Accepts a miss request from the
//  TLB, reads level-1 and (if needed) level-0 PTEs over a single-outstanding memory read port,

---
 rtl/sv32_page_walker.sv | 189 ++++++++++++++++++
 tb/tb_sv32_page_walker.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv32_page_walker.sv
// Sv32 two-level hardware page-table walker: turns a TLB miss into one or two PTE reads
// and returns either a TLB fill or a page-fault pulse.
module sv32_page_walker (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    input  logic        req_rnw,
    input  logic        req_execute,
    input  logic        abort_request,
    input  logic [19:0] satp_ppn,
    input  logic        mxr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rdata_valid,
    input  logic [31:0] mem_rdata,
    output logic        write_entry,
    output logic [19:0] upper_phys_addr,
    output logic        superpage,
    output logic [7:0]  perms,
    output logic        is_fault,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_L1_REQ  = 3'd1;
    localparam logic [2:0] ST_L1_WAIT = 3'd2;
    localparam logic [2:0] ST_L0_REQ  = 3'd3;
    localparam logic [2:0] ST_L0_WAIT = 3'd4;
    localparam logic [2:0] ST_DRAIN   = 3'd5;

    logic [2:0]  state_reg, state_next;
    logic [19:0] vpn_reg;
    logic        rnw_reg;
    logic        exec_reg;
    logic [19:0] ptr_ppn_reg;
    logic        write_entry_reg, write_entry_next;
    logic        is_fault_reg, is_fault_next;
    logic [19:0] upper_reg;
    logic        superpage_reg, superpage_next;
    logic [7:0]  perms_reg;
    logic        latch_req;
    logic        load_ptr;

    // Decoded view of the PTE currently on the response bus.
    logic pte_v, pte_r, pte_w, pte_x, pte_a, pte_d;
    logic pte_bad, pte_leaf, leaf_bad, l1_fault, l0_fault;
    logic is_store, is_load;

    assign pte_v = mem_rdata[0];
    assign pte_r = mem_rdata[1];
    assign pte_w = mem_rdata[2];
    assign pte_x = mem_rdata[3];
    assign pte_a = mem_rdata[6];
    assign pte_d = mem_rdata[7];

    assign is_store = ~rnw_reg;
    assign is_load  = rnw_reg & ~exec_reg;

    assign pte_bad  = ~pte_v | (pte_w & ~pte_r) | (|mem_rdata[31:30]);
    assign pte_leaf = pte_r | pte_x;
    assign leaf_bad = ~pte_a
                    | (is_store & (~pte_w | ~pte_d))
                    | (exec_reg & ~pte_x)
                    | (is_load & ~pte_r & ~(mxr & pte_x));

    // A level-1 leaf must also have a zero low PPN field to be a legal 4MB mapping.
    assign l1_fault = pte_bad | (pte_leaf & ((|mem_rdata[19:10]) | leaf_bad));
    assign l0_fault = pte_bad | ~pte_leaf | leaf_bad;

    always_comb begin
        state_next       = state_reg;
        write_entry_next = 1'b0;
        is_fault_next    = 1'b0;
        superpage_next   = 1'b0;
        latch_req        = 1'b0;
        load_ptr         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!abort_request && req_valid) begin
                    latch_req  = 1'b1;
                    state_next = ST_L1_REQ;
                end
            end
            ST_L1_REQ: begin
                if (mem_req_ready) begin
                    state_next = abort_request ? ST_DRAIN : ST_L1_WAIT;
                end else if (abort_request) begin
                    state_next = ST_IDLE;
                end
            end
            ST_L1_WAIT: begin
                if (mem_rdata_valid) begin
                    if (abort_request) begin
                        state_next = ST_IDLE;
                    end else if (l1_fault) begin
                        is_fault_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else if (pte_leaf) begin
                        write_entry_next = 1'b1;
                        superpage_next   = 1'b1;
                        state_next       = ST_IDLE;
                    end else begin
                        load_ptr   = 1'b1;
                        state_next = ST_L0_REQ;
                    end
                end else if (abort_request) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_L0_REQ: begin
                if (mem_req_ready) begin
                    state_next = abort_request ? ST_DRAIN : ST_L0_WAIT;
                end else if (abort_request) begin
                    state_next = ST_IDLE;
                end
            end
            ST_L0_WAIT: begin
                if (mem_rdata_valid) begin
                    if (abort_request) begin
                        state_next = ST_IDLE;
                    end else if (l0_fault) begin
                        is_fault_next = 1'b1;
                        state_next    = ST_IDLE;
                    end else begin
                        write_entry_next = 1'b1;
                        state_next       = ST_IDLE;
                    end
                end else if (abort_request) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rdata_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            vpn_reg         <= 20'd0;
            rnw_reg         <= 1'b0;
            exec_reg        <= 1'b0;
            ptr_ppn_reg     <= 20'd0;
            write_entry_reg <= 1'b0;
            is_fault_reg    <= 1'b0;
            upper_reg       <= 20'd0;
            superpage_reg   <= 1'b0;
            perms_reg       <= 8'd0;
        end else begin
            state_reg       <= state_next;
            write_entry_reg <= write_entry_next;
            is_fault_reg    <= is_fault_next;
            if (latch_req) begin
                vpn_reg  <= req_vaddr[31:12];
                rnw_reg  <= req_rnw;
                exec_reg <= req_execute;
            end
            if (load_ptr) begin
                ptr_ppn_reg <= mem_rdata[29:10];
            end
            if (write_entry_next) begin
                upper_reg     <= mem_rdata[29:10];
                superpage_reg <= superpage_next;
                perms_reg     <= mem_rdata[7:0];
            end
        end
    end

    assign mem_req_valid   = (state_reg == ST_L1_REQ) || (state_reg == ST_L0_REQ);
    assign mem_addr        = (state_reg == ST_L0_REQ) ? {ptr_ppn_reg, vpn_reg[9:0], 2'b00}
                                                      : {satp_ppn, vpn_reg[19:10], 2'b00};
    assign write_entry     = write_entry_reg;
    assign is_fault        = is_fault_reg;
    assign upper_phys_addr = upper_reg;
    assign superpage       = superpage_reg;
    assign perms           = perms_reg;
    assign busy            = (state_reg != ST_IDLE);

    // Page offset and RSW bits play no part in translation.
    logic unused_bits;
    assign unused_bits = ^{req_vaddr[11:0], mem_rdata[9:8]};

endmodule

// File: tb/tb_sv32_page_walker.sv
// Randomized scoreboard bench for sv32_page_walker with a rule-level Sv32 walk model
// and a responder that plays the memory port.
module tb_sv32_page_walker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid;
    logic [31:0] req_vaddr;
    logic        req_rnw;
    logic        req_execute;
    logic        abort_request;
    logic [19:0] satp_ppn;
    logic        mxr;
    logic        mem_req_valid;
    wire         mem_req_ready;
    logic [31:0] mem_addr;
    wire         mem_rdata_valid;
    wire  [31:0] mem_rdata;
    logic        write_entry;
    logic [19:0] upper_phys_addr;
    logic        superpage;
    logic [7:0]  perms;
    logic        is_fault;
    logic        busy;

    sv32_page_walker dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_vaddr(req_vaddr),
        .req_rnw(req_rnw), .req_execute(req_execute), .abort_request(abort_request),
        .satp_ppn(satp_ppn), .mxr(mxr), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .write_entry(write_entry), .upper_phys_addr(upper_phys_addr),
        .superpage(superpage), .perms(perms), .is_fault(is_fault), .busy(busy)
    );

    typedef struct {
        bit         fault;
        logic [19:0] ppn;
        bit         sp;
        logic [7:0] prm;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [bit [31:0]];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_pulse_cyc = 0;
    int          req_cyc = 0;
    int          n_walks = 0;

    // Memory port: automatic responder or direct manual drive.
    logic        auto_mode = 1'b1;
    logic        fast_mode = 1'b1;
    logic        auto_ready = 1'b0, auto_rvalid = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    logic        man_ready = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    assign mem_req_ready   = auto_mode ? auto_ready  : man_ready;
    assign mem_rdata_valid = auto_mode ? auto_rvalid : man_rvalid;
    assign mem_rdata       = auto_mode ? auto_rdata  : man_rdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    endtask

    function automatic bit pte_bad(input logic [31:0] p);
        return !p[0] || (p[2] && !p[1]) || (p[31:30] != 2'b00);
    endfunction

    function automatic bit perm_ok(input logic [31:0] p, input bit rnw, input bit exe, input bit mx);
        if (!p[6]) return 1'b0;
        if (!rnw && (!p[2] || !p[7])) return 1'b0;
        if (exe && !p[3]) return 1'b0;
        if (rnw && !exe && !p[1] && !(mx && p[3])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'd0;
    endfunction

    // Sv32 translation straight from the architectural rules.
    function automatic exp_t ref_walk(input logic [31:0] va, input bit rnw, input bit exe,
                                      input bit mx, input logic [19:0] satp);
        exp_t        e;
        logic [31:0] p;
        logic [31:0] a;
        e.fault = 1'b1; e.ppn = 20'd0; e.sp = 1'b0; e.prm = 8'd0;
        a = {satp, va[31:22], 2'b00};
        p = rd(a);
        if (pte_bad(p)) return e;
        if (p[1] || p[3]) begin
            if (p[19:10] != 10'd0 || !perm_ok(p, rnw, exe, mx)) return e;
            e.fault = 1'b0; e.ppn = p[29:10]; e.sp = 1'b1; e.prm = p[7:0];
            return e;
        end
        a = {p[29:10], va[21:12], 2'b00};
        p = rd(a);
        if (pte_bad(p) || !(p[1] || p[3]) || !perm_ok(p, rnw, exe, mx)) return e;
        e.fault = 1'b0; e.ppn = p[29:10]; e.sp = 1'b0; e.prm = p[7:0];
        return e;
    endfunction

    // Responder: random ready and latency, or zero-wait when fast_mode is set.
    initial begin : responder
        logic        pending;
        int          cnt;
        logic [31:0] resp;
        pending = 1'b0; cnt = 0; resp = 32'd0;
        forever begin
            @(negedge clk);
            auto_rvalid = 1'b0;
            if (!auto_mode) begin
                pending    = 1'b0;
                auto_ready = 1'b0;
            end else begin
                if (pending) begin
                    if (cnt == 0) begin
                        auto_rvalid = 1'b1;
                        auto_rdata  = resp;
                        pending     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                auto_ready = pending ? 1'b0 : (fast_mode ? 1'b1 : ($urandom_range(0, 3) != 0));
                if (!pending && mem_req_valid && auto_ready) begin
                    check("mem_addr_known", 32'(mem.exists(mem_addr)), 32'd1);
                    resp    = rd(mem_addr);
                    pending = 1'b1;
                    cnt     = fast_mode ? 0 : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // Monitor: every result pulse is matched against the oldest expected walk.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (write_entry || is_fault) begin
                last_pulse_cyc = cyc;
                check("pulse_exclusive", 32'(write_entry && is_fault), 32'd0);
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'({write_entry, is_fault}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    n_walks++;
                    $display("walk %0d: fault=%0d ppn=0x%05h sp=%0d perms=0x%02h",
                             n_walks, is_fault, upper_phys_addr, superpage, perms);
                    check("is_fault", 32'(is_fault), 32'(e.fault));
                    check("write_entry", 32'(write_entry), 32'(!e.fault));
                    if (!e.fault) begin
                        check("upper_phys_addr", 32'(upper_phys_addr), 32'(e.ppn));
                        check("superpage", 32'(superpage), 32'(e.sp));
                        check("perms", 32'(perms), 32'(e.prm));
                    end
                end
            end
        end
    end

    task automatic do_walk(input logic [31:0] va, input bit rnw, input bit exe,
                           input logic [19:0] satp, input bit mx, input int lat);
        sb.push_back(ref_walk(va, rnw, exe, mx, satp));
        @(negedge clk);
        satp_ppn = satp; mxr = mx; req_vaddr = va; req_rnw = rnw; req_execute = exe;
        req_valid = 1'b1;
        req_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 300 && (sb.size() != 0 || busy); i++) @(negedge clk);
        if (sb.size() != 0 || busy) begin
            check("walk_timeout", 32'd1, 32'd0);
            sb.delete();
        end else if (lat >= 0) begin
            check("latency", 32'(last_pulse_cyc - req_cyc), 32'(lat));
        end
    endtask

    task automatic directed(input logic [31:0] l1, input logic [31:0] l0, input bit rnw, input int lat);
        logic [31:0] va;
        va = 32'h0040_3000;
        mem.delete();
        mem[{20'h00100, va[31:22], 2'b00}] = l1;
        if (l1[0] && !l1[1] && !l1[3]) mem[{l1[29:10], va[21:12], 2'b00}] = l0;
        do_walk(va, rnw, 1'b0, 20'h00100, 1'b0, lat);
    endtask

    task automatic issue_req(input logic [31:0] va, input bit rnw);
        @(negedge clk);
        satp_ppn = 20'h00100; mxr = 1'b0; req_vaddr = va; req_rnw = rnw; req_execute = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 20 && !mem_req_valid; i++) @(negedge clk);
        check("mem_req_seen", 32'(mem_req_valid), 32'd1);
    endtask

    task automatic man_handshake();
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
    endtask

    task automatic man_respond(input logic [31:0] d);
        man_rvalid = 1'b1; man_rdata = d;
        @(negedge clk);
        man_rvalid = 1'b0;
    endtask

    function automatic logic [31:0] rand_leaf_flags();
        logic [7:0] f;
        f = 8'($urandom) | 8'h01;
        if (!f[1] && !f[3]) f[1] = 1'b1;
        f[6] = ($urandom_range(0, 4) != 0);
        f[7] = ($urandom_range(0, 3) != 0);
        return {24'd0, f};
    endfunction

    initial begin : stimulus
        logic [31:0] va, l1, l0, a0, fl;
        logic [19:0] satp, rp;
        bit          rnw, exe, mx;
        int          kind;

        rst = 1'b0; req_valid = 1'b0; req_vaddr = 32'd0; req_rnw = 1'b1; req_execute = 1'b0;
        abort_request = 1'b0; satp_ppn = 20'd0; mxr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_write_entry", 32'(write_entry), 32'd0);
        check("rst_is_fault", 32'(is_fault), 32'd0);
        check("rst_upper", 32'(upper_phys_addr), 32'd0);
        check("rst_superpage", 32'(superpage), 32'd0);
        check("rst_perms", 32'(perms), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Zero-wait directed walks.
        fast_mode = 1'b1;
        directed(32'h0000_00CF, 32'd0, 1'b1, 3);
        directed(32'h0008_0001, 32'h1234_50DB, 1'b1, 5);
        directed(32'h0008_0001, 32'h1234_50DB, 1'b0, 5);
        directed(32'h0000_00CE, 32'd0, 1'b1, 3);
        directed(32'h0000_040F, 32'd0, 1'b1, 3);
        directed(32'h0008_0001, 32'h1234_505B, 1'b0, 5);
        directed(32'h0008_0001, 32'h1234_50DF, 1'b0, 5);

        // Randomized walks with random ready and latency.
        fast_mode = 1'b0;
        for (int n = 0; n < 250; n++) begin
            va = $urandom; satp = 20'($urandom); mx = 1'($urandom_range(0, 1));
            exe = ($urandom_range(0, 3) == 0);
            rnw = exe ? 1'b1 : 1'($urandom_range(0, 1));
            mem.delete();
            kind = int'($urandom_range(0, 9));
            rp = 20'($urandom);
            fl = rand_leaf_flags();
            if (kind == 0) l1 = $urandom;
            else if (kind <= 3) l1 = {2'b00, rp[19:10], ($urandom_range(0, 4) == 0) ? rp[9:0] : 10'd0, 2'b00, fl[7:0]};
            else l1 = {($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00, rp, 2'b00, 8'h01};
            mem[{satp, va[31:22], 2'b00}] = l1;
            if (!pte_bad(l1) && !l1[1] && !l1[3]) begin
                a0 = {l1[29:10], va[21:12], 2'b00};
                rp = 20'($urandom);
                fl = rand_leaf_flags();
                kind = int'($urandom_range(0, 9));
                if (kind == 0) l0 = $urandom;
                else if (kind == 1) l0 = {2'b00, rp, 2'b00, 8'h01};
                else l0 = {($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00, rp, 2'b00, fl[7:0]};
                mem[a0] = l0;
            end
            do_walk(va, rnw, exe, satp, mx, -1);
        end

        // Abort during L0_WAIT; response three cycles later is swallowed.
        auto_mode = 1'b0;
        va = 32'h0040_3000;
        mem.delete();
        issue_req(va, 1'b1);
        wait_mem_req();
        check("l1_addr", mem_addr, 32'h0010_0004);
        man_handshake();
        man_respond(32'h0008_0001);
        wait_mem_req();
        check("l0_addr", mem_addr, {20'h00200, va[21:12], 2'b00});
        man_handshake();
        abort_request = 1'b1;
        @(negedge clk);
        abort_request = 1'b0;
        check("drain_busy", 32'(busy), 32'd1);
        check("drain_no_req", 32'(mem_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        man_respond(32'h1234_50DB);
        check("drain_done_idle", 32'(busy), 32'd0);
        check("drain_no_fill", 32'(write_entry), 32'd0);

        // A fresh request is accepted after the drain.
        auto_mode = 1'b1; fast_mode = 1'b1;
        directed(32'h0000_00CF, 32'd0, 1'b1, 3);

        // Abort in L1_REQ with no handshake returns straight to idle.
        auto_mode = 1'b0;
        issue_req(va, 1'b1);
        wait_mem_req();
        abort_request = 1'b1;
        @(negedge clk);
        abort_request = 1'b0;
        check("abort_req_idle", 32'(busy), 32'd0);
        check("abort_req_no_req", 32'(mem_req_valid), 32'd0);

        // Abort on the handshake cycle goes through DRAIN.
        issue_req(va, 1'b1);
        wait_mem_req();
        man_ready = 1'b1; abort_request = 1'b1;
        @(negedge clk);
        man_ready = 1'b0; abort_request = 1'b0;
        check("abort_hs_drain", 32'(busy), 32'd1);
        man_respond(32'h0000_00CF);
        check("abort_hs_idle", 32'(busy), 32'd0);

        // Abort together with the deciding response suppresses the fill.
        issue_req(va, 1'b1);
        wait_mem_req();
        man_handshake();
        abort_request = 1'b1;
        man_respond(32'h0000_00CF);
        abort_request = 1'b0;
        check("abort_resp_no_fill", 32'(write_entry), 32'd0);
        check("abort_resp_no_fault", 32'(is_fault), 32'd0);
        check("abort_resp_idle", 32'(busy), 32'd0);

        // Reset during L1_WAIT clears everything; the late response is ignored.
        issue_req(va, 1'b1);
        wait_mem_req();
        man_handshake();
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("midrst_upper", 32'(upper_phys_addr), 32'd0);
        check("midrst_perms", 32'(perms), 32'd0);
        check("midrst_superpage", 32'(superpage), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        man_respond(32'h0000_00CF);
        repeat (2) @(negedge clk);
        check("stray_idle", 32'(busy), 32'd0);
        check("stray_no_fill", 32'(write_entry), 32'd0);
        check("stray_perms_held", 32'(perms), 32'd0);

        auto_mode = 1'b1;
        directed(32'h0008_0001, 32'h1234_50DB, 1'b1, 5);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
